// File: rtl/dmem_responder.sv
// Data-memory responder: serves load/store requests after WAIT_CYCLES wait states.
// Define DMEM_ACCESS_COUNT_EN to enable the read_count/write_count completion counters.
module dmem_responder #(
    parameter int unsigned DATA_WIDTH    = 20,
    parameter int unsigned ADDRESS_WIDTH = 8,
    parameter int unsigned MEM_SIZE      = 256,
    parameter int unsigned WAIT_CYCLES   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mem_read,
    input  logic                     mem_write,
    input  logic                     byte_enable,
    input  logic [ADDRESS_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0]    write_data,
    output logic [DATA_WIDTH-1:0]    read_data,
    output logic                     mem_stall,
    output logic                     mem_ready,
    output logic                     addr_err,
    output logic [15:0]              read_count,
    output logic [15:0]              write_count
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam logic [ADDRESS_WIDTH:0] MEM_LIMIT = (ADDRESS_WIDTH+1)'(MEM_SIZE);
    localparam logic [3:0]             WAIT_LAST = 4'(WAIT_CYCLES - 1);

    state_t                  state_q, state_d;
    logic [3:0]              wait_cnt_q, wait_cnt_d;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic                    be_q;
    logic                    store_q;
    logic [DATA_WIDTH-1:0]   read_data_q;
    logic                    mem_ready_q;
    logic                    addr_err_q;
    logic [DATA_WIDTH-1:0]   mem_q [MEM_SIZE];

    logic [ADDRESS_WIDTH-1:0] acc_addr;
    logic [DATA_WIDTH-1:0]   acc_wdata;
    logic                    acc_be;
    logic                    acc_store;
    logic                    acc_in_range;
    logic                    enter_done;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic [DATA_WIDTH-1:0]   load_val;

    // With WAIT_CYCLES=0 the access completes on the accept edge, so the live inputs
    // are used in IDLE and the captured copies afterwards.
    always_comb begin
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        acc_be    = be_q;
        acc_store = store_q;
        if (state_q == IDLE) begin
            acc_addr  = address;
            acc_wdata = write_data;
            acc_be    = byte_enable;
            acc_store = mem_write;
        end
    end

    assign acc_in_range = {1'b0, acc_addr} < MEM_LIMIT;
    assign enter_done   = (state_d == DONE) && !rst;
    assign rd_word      = acc_in_range ? mem_q[acc_addr] : '0;
    assign load_val     = acc_be ? DATA_WIDTH'(rd_word[7:0]) : rd_word;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (mem_read || mem_write) begin
                    wait_cnt_d = '0;
                    state_d    = (WAIT_CYCLES == 0) ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt_q == WAIT_LAST) state_d = DONE;
                else                         wait_cnt_d = wait_cnt_q + 4'd1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        mem_stall = !rst && (((state_q == IDLE) && (mem_read || mem_write)) || (state_q == WAIT));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= 1'b0;
            store_q     <= 1'b0;
            read_data_q <= '0;
            mem_ready_q <= 1'b0;
            addr_err_q  <= 1'b0;
        end else begin
            if (state_q == IDLE && (mem_read || mem_write)) begin
                addr_q  <= address;
                wdata_q <= write_data;
                be_q    <= byte_enable;
                store_q <= mem_write;
            end
            mem_ready_q <= enter_done;
            addr_err_q  <= enter_done && !acc_in_range;
            if (enter_done && !acc_store) read_data_q <= load_val;
        end
    end

    // Array is deliberately not reset; only an in-range store reaching DONE commits.
    always_ff @(posedge clk) begin
        if (enter_done && acc_store && acc_in_range) begin
            if (acc_be) mem_q[acc_addr] <= {mem_q[acc_addr][DATA_WIDTH-1:8], acc_wdata[7:0]};
            else        mem_q[acc_addr] <= acc_wdata;
        end
    end

    assign read_data = read_data_q;
    assign mem_ready = mem_ready_q;
    assign addr_err  = addr_err_q;

`ifdef DMEM_ACCESS_COUNT_EN
    logic [15:0] read_count_q;
    logic [15:0] write_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            read_count_q  <= '0;
            write_count_q <= '0;
        end else if (enter_done) begin
            if (acc_store) write_count_q <= write_count_q + 16'd1;
            else           read_count_q  <= read_count_q + 16'd1;
        end
    end

    assign read_count  = read_count_q;
    assign write_count = write_count_q;
`else
    assign read_count  = '0;
    assign write_count = '0;
`endif

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder serving the pipeline's load/store requests (mem_read / mem_write / byte_enable, address, write data) with a configurable number of wait states.
- Holds the word array and returns read data.
- Drives a stall back to the pipeline hazard logic while a request is in service.
- Sits between the MEM stage and the data memory array, on the far end of the pipeline's memory interface.

Parameters:
DATA_WIDTH, 20, word width in bits
ADDRESS_WIDTH, 8, word address width
MEM_SIZE, 256, number of words implemented (<= 2**ADDRESS_WIDTH)
WAIT_CYCLES, 2, extra wait states per access (0..15)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset
mem_read  input  1  load request from MEM stage
mem_write  input  1  store request from MEM stage
byte_enable  input  1  1 = byte access (bits [7:0]), 0 = full word
address  input  ADDRESS_WIDTH  word address
write_data  input  DATA_WIDTH  store data
read_data  output  DATA_WIDTH  load result, registered
mem_stall  output  1  pipeline must hold MEM stage and earlier
mem_ready  output  1  one-cycle pulse: access complete, read_data valid
addr_err  output  1  one-cycle pulse with mem_ready: address >= MEM_SIZE
read_count  output  16  completed loads (optional feature)
write_count  output  16  completed stores (optional feature)

Behaviour:
- Single clock clk; reset rst is synchronous and active-high.
- Reset values:
  - state IDLE, wait counter 0.
  - read_data 0, mem_ready 0, addr_err 0, counters 0.
  - mem_stall 0 while rst is high.
  - Array contents are not cleared by reset.
- States:
  - IDLE -> WAIT when mem_read|mem_write is high. In this accept cycle T, capture address, write_data, byte_enable and op.
  - WAIT counts WAIT_CYCLES cycles. With WAIT_CYCLES=0 it is skipped (IDLE -> DONE).
  - WAIT -> DONE when the counter reaches WAIT_CYCLES-1.
  - DONE -> IDLE unconditionally.
- mem_stall:
  - Combinational.
  - High in the IDLE accept cycle and in every WAIT cycle.
  - Low in DONE and in idle IDLE.
  - Total stall = 1+WAIT_CYCLES cycles; mem_ready pulses in cycle T+1+WAIT_CYCLES.
- DONE cycle:
  - The pipeline still presents the same request and advances at the end of DONE.
  - The responder returns to IDLE without re-accepting it.
  - The next IDLE cycle's request belongs to the next instruction.
- Store commit:
  - Committed on the rising edge entering DONE.
  - byte_enable=1: only bits [7:0] written, bits [DATA_WIDTH-1:8] preserved.
  - byte_enable=0: full word written.
- Load:
  - read_data loaded on the edge entering DONE.
  - byte_enable=1: zero-extended bits [7:0]; byte_enable=0: full word.
  - read_data holds its value until the next completed load. Stores do not change it.
- Both mem_read and mem_write high: treated as store. read_data unchanged.
- Address >= MEM_SIZE:
  - Store ignored; load returns 0.
  - addr_err pulses together with mem_ready.
  - Full stall timing still applies.
- Inputs changing during WAIT are ignored; the captured values are used.
- rst during WAIT/DONE:
  - Return to IDLE; pending store is not committed.
  - mem_ready does not pulse; mem_stall drops in the reset cycle.
- Address wraps only by truncation to ADDRESS_WIDTH; there is no auto-increment.

Optional Feature:
- DMEM_ACCESS_COUNT_EN defined:
  - read_count increments on every mem_ready for a load; write_count on every mem_ready for a store, including addr_err accesses.
  - Both are 16-bit, wrap 0xFFFF -> 0x0000, and are cleared by rst.
- Not defined: read_count and write_count are tied to 0 and no counter flops are generated. Ports exist in both builds.

Test Plan:
- Reset then idle 5 cycles -> read_data=0, mem_stall=0, mem_ready=0, addr_err=0 throughout.
- WAIT_CYCLES=2: store word 0x3A5C1 to addr 0x10 at cycle T -> mem_stall high T..T+2, mem_ready at T+3. Then load 0x10 -> read_data=0x3A5C1 at mem_ready, 3 stall cycles.
- Byte store 0x000FF with byte_enable=1 to addr 0x10 (holding 0x3A5C1) -> word load returns 0x3A5FF; byte load returns 0x000FF.
- Load addr 0xFF with MEM_SIZE=200 -> read_data=0, addr_err and mem_ready pulse together. Store to 0xFF -> no array change, addr_err pulses.
- Store to 0x20 with rst asserted in the WAIT cycle -> no mem_ready, state IDLE; later load of 0x20 returns its prior contents.
- DMEM_ACCESS_COUNT_EN, WAIT_CYCLES=0: 3 loads and 2 stores back-to-back (each accept followed by DONE) -> read_count=3, write_count=2, each access stalls exactly 1 cycle. Without the macro both counters read 0.
